// File: rtl/rv32_alu.sv
// rv32_alu: combinational RV32I ALU for the execute stage, plus a one-cycle
// registered copy of the result for pipelined consumers.
// Optional feature macro: RV32_ALU_LUI_EN (opcode 01011 passes alu_b through;
// without it, 01011 behaves as an undefined opcode and returns 0).
// There is no handshake: alu_result follows the inputs in the same cycle and
// alu_result_q samples it on every rising clk edge with no valid/ready gating.
module rv32_alu (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_a,
  input  logic [31:0] alu_b,
  input  logic [4:0]  alu_op,
  output logic [31:0] alu_result,
  output logic [31:0] alu_result_q
);

  localparam logic [4:0] OP_ADD   = 5'b00000;
  localparam logic [4:0] OP_SUB   = 5'b00001;
  localparam logic [4:0] OP_SLL   = 5'b00010;
  localparam logic [4:0] OP_SLT   = 5'b00011;
  localparam logic [4:0] OP_SLTU  = 5'b00100;
  localparam logic [4:0] OP_XOR   = 5'b00101;
  localparam logic [4:0] OP_SRL   = 5'b00110;
  localparam logic [4:0] OP_SRA   = 5'b00111;
  localparam logic [4:0] OP_OR    = 5'b01000;
  localparam logic [4:0] OP_AND   = 5'b01001;
  localparam logic [4:0] OP_BEQ   = 5'b01010;
  localparam logic [4:0] OP_LUI   = 5'b01011;
  localparam logic [4:0] OP_AUIPC = 5'b01100;
  localparam logic [4:0] OP_BNE   = 5'b01101;
  localparam logic [4:0] OP_BLT   = 5'b01110;
  localparam logic [4:0] OP_BGE   = 5'b01111;
  localparam logic [4:0] OP_BLTU  = 5'b10000;
  localparam logic [4:0] OP_BGEU  = 5'b10001;

  logic [4:0]  shamt;
  logic        lt_s;
  logic        lt_u;
  logic        eq;
  logic [31:0] result_d;

  // Only the low five bits of operand B select the shift distance.
  assign shamt = alu_b[4:0];
  assign lt_s  = $signed(alu_a) < $signed(alu_b);
  assign lt_u  = alu_a < alu_b;
  assign eq    = alu_a == alu_b;

  // Result select; compares return a 0/1 word, unknown opcodes return zero.
  always_comb begin
    result_d = 32'd0;
    case (alu_op)
      OP_ADD:   result_d = alu_a + alu_b;
      OP_SUB:   result_d = alu_a - alu_b;
      OP_SLL:   result_d = alu_a << shamt;
      OP_SLT:   result_d = {31'd0, lt_s};
      OP_SLTU:  result_d = {31'd0, lt_u};
      OP_XOR:   result_d = alu_a ^ alu_b;
      OP_SRL:   result_d = alu_a >> shamt;
      OP_SRA:   result_d = $signed(alu_a) >>> shamt;
      OP_OR:    result_d = alu_a | alu_b;
      OP_AND:   result_d = alu_a & alu_b;
      OP_BEQ:   result_d = {31'd0, eq};
`ifdef RV32_ALU_LUI_EN
      OP_LUI:   result_d = alu_b;
`else
      // The decoder routes LUI as ADD with alu_a=0 in this build.
      OP_LUI:   result_d = 32'd0;
`endif
      OP_AUIPC: result_d = alu_a + alu_b;
      OP_BNE:   result_d = {31'd0, ~eq};
      OP_BLT:   result_d = {31'd0, lt_s};
      OP_BGE:   result_d = {31'd0, ~lt_s};
      OP_BLTU:  result_d = {31'd0, lt_u};
      OP_BGEU:  result_d = {31'd0, ~lt_u};
      default:  result_d = 32'd0;
    endcase
  end

  assign alu_result = result_d;

  // Registered copy of the result; reset clears it without waiting for clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) alu_result_q <= 32'd0;
    else     alu_result_q <= result_d;
  end

endmodule

// File: tb/tb_rv32_alu.sv
// tb_rv32_alu: table-driven directed vectors for rv32_alu, followed by
// hand-written sequences for the registered output and asynchronous reset.
module tb_rv32_alu;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        rst;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  alu_op;
  logic [31:0] alu_result;
  logic [31:0] alu_result_q;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  rv32_alu dut (
    .clk          (clk),
    .rst          (rst),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_result   (alu_result),
    .alu_result_q (alu_result_q)
  );

  // ---------------- vector table ----------------
  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  int checks   = 0;
  int failures = 0;

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic add_vec(input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    alu_op = op;
    alu_a  = a;
    alu_b  = b;
  endtask

  logic [31:0] lui_exp;

  initial begin
`ifdef RV32_ALU_LUI_EN
    lui_exp = 32'h1234_5000;
`else
    lui_exp = 32'h0000_0000;
`endif
    // op, a, b, expected
    add_vec(5'b00000, 32'd10,          32'd5,          32'd15);
    add_vec(5'b00001, 32'd10,          32'd5,          32'd5);
    add_vec(5'b00001, 32'd0,           32'd1,          32'hFFFF_FFFF);
    add_vec(5'b00000, 32'hFFFF_FFFF,   32'd1,          32'd0);
    add_vec(5'b01001, 32'h0F0F_0F0F,   32'h00FF_00FF,  32'h000F_000F);
    add_vec(5'b01000, 32'h0F0F_0F0F,   32'h00FF_00FF,  32'h0FFF_0FFF);
    add_vec(5'b00101, 32'h0F0F_0F0F,   32'h00FF_00FF,  32'h0FF0_0FF0);
    add_vec(5'b01100, 32'h1000_0000,   32'd4,          32'h1000_0004);
    add_vec(5'b00010, 32'h0000_000F,   32'd1,          32'h0000_001E);
    add_vec(5'b00110, 32'h0000_00F0,   32'd4,          32'h0000_000F);
    add_vec(5'b00111, 32'hFFFF_FFF0,   32'd4,          32'hFFFF_FFFF);
    add_vec(5'b00010, 32'h0000_0001,   32'h0000_0021,  32'h0000_0002);
    add_vec(5'b00010, 32'h0000_0001,   32'd31,         32'h8000_0000);
    add_vec(5'b00110, 32'h8000_0000,   32'd31,         32'h0000_0001);
    add_vec(5'b00111, 32'h7FFF_FFF0,   32'd4,          32'h07FF_FFFF);
    add_vec(5'b00111, 32'h8000_0000,   32'h0000_0024,  32'hF800_0000);
    add_vec(5'b00011, 32'd3,           32'd5,          32'd1);
    add_vec(5'b00011, 32'd5,           32'd3,          32'd0);
    add_vec(5'b00100, 32'd3,           32'd5,          32'd1);
    add_vec(5'b00100, 32'd5,           32'd3,          32'd0);
    add_vec(5'b00011, 32'hFFFF_FFFF,   32'd1,          32'd1);
    add_vec(5'b00100, 32'hFFFF_FFFF,   32'd1,          32'd0);
    add_vec(5'b00011, 32'd7,           32'd7,          32'd0);
    add_vec(5'b01010, 32'd123,         32'd123,        32'd1);
    add_vec(5'b01010, 32'd123,         32'd456,        32'd0);
    add_vec(5'b01101, 32'd123,         32'd456,        32'd1);
    add_vec(5'b01101, 32'd789,         32'd789,        32'd0);
    add_vec(5'b01111, 32'hFFFF_FFFB,   32'hFFFF_FFF6,  32'd1);
    add_vec(5'b01111, 32'd5,           32'd5,          32'd1);
    add_vec(5'b01111, 32'hFFFF_FFFF,   32'd0,          32'd0);
    add_vec(5'b01110, 32'd5,           32'd10,         32'd1);
    add_vec(5'b01110, 32'd5,           32'd5,          32'd0);
    add_vec(5'b01110, 32'hFFFF_FFFF,   32'd0,          32'd1);
    add_vec(5'b10001, 32'hF000_0000,   32'h1000_0000,  32'd1);
    add_vec(5'b10001, 32'd1,           32'h10,         32'd0);
    add_vec(5'b10000, 32'd1,           32'h10,         32'd1);
    add_vec(5'b10000, 32'hF000_0000,   32'h1000_0000,  32'd0);
    add_vec(5'b10010, 32'hDEAD_BEEF,   32'h1234_5678,  32'd0);
    add_vec(5'b11111, 32'hFFFF_FFFF,   32'hFFFF_FFFF,  32'd0);
    add_vec(5'b01011, 32'hAAAA_AAAA,   32'h1234_5000,  lui_exp);

    // ---------------- reset state ----------------
    rst = 1'b1;
    drive(5'b00000, 32'd1, 32'd2);
    repeat (2) @(posedge clk);
    #1;
    check("reset_q", alu_result_q, 32'd0);
    check("reset_comb", alu_result, 32'd3);
    @(negedge clk);
    rst = 1'b0;

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].op, vecs[i].a, vecs[i].b);
      #1;
      check($sformatf("vec%0d_op%05b_comb", i, vecs[i].op), alu_result, vecs[i].exp);
      exp_q.push_back(vecs[i].exp);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_op%05b_q", i, vecs[i].op), alu_result_q, exp_q.pop_front());
    end

    // ---------------- register latency and async reset ----------------
    @(negedge clk);
    drive(5'b00001, 32'd100, 32'd1);
    @(posedge clk);
    #1;
    check("q_prev_value", alu_result_q, 32'd99);
    drive(5'b00000, 32'd10, 32'd5);
    #1;
    check("q_holds_between_edges", alu_result_q, 32'd99);
    check("comb_zero_latency", alu_result, 32'd15);
    @(posedge clk);
    #1;
    check("q_after_edge", alu_result_q, 32'd15);

    #2;
    rst = 1'b1;
    #1;
    check("q_async_clear", alu_result_q, 32'd0);
    check("comb_ignores_rst", alu_result, 32'd15);
    @(posedge clk);
    #1;
    check("q_held_in_rst", alu_result_q, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("q_zero_after_release", alu_result_q, 32'd0);
    @(posedge clk);
    #1;
    check("q_resume_capture", alu_result_q, 32'd15);

    // ---------------- final report ----------------
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: got %0d leftover entries expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
